// File: rtl/float_adder_scheduler.sv
// float_adder_scheduler: round-robin sharing of one external E4M3 adder among NUM_REQ requesters.
// Define FADD_SCHED_TIMEOUT_EN to bound WAIT; expiry returns rsp_y=0 with rsp_error=1.
module float_adder_scheduler #(
   parameter int NUM_REQ        = 4,
   parameter int ID_W           = 2,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [NUM_REQ-1:0]   req_valid,
   output logic [NUM_REQ-1:0]   req_ready,
   input  logic [8*NUM_REQ-1:0] req_a,
   input  logic [8*NUM_REQ-1:0] req_b,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [7:0]           rsp_y,
   output logic [ID_W-1:0]      rsp_id,
   output logic                 rsp_error,
   output logic [7:0]           adder_a,
   output logic [7:0]           adder_b,
   output logic                 adder_reset,
   input  logic [7:0]           adder_y,
   input  logic                 adder_valid
);
   typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESP} state_t;
   state_t          r_state;
   logic [ID_W-1:0] r_ptr, r_id, r_rsp_id, w_gnt;
   logic [7:0]      r_a, r_b, r_y, w_a, w_b;
   logic            r_rsp_valid, r_err, w_any, w_expire;
   // Pass 0 scans requesters at or below the pointer, pass 1 those above it; later hits win,
   // so the lowest index above the pointer has top priority, then wrap to the lowest index.
   always_comb begin
      w_any = 1'b0;
      w_gnt = '0;
      w_a   = '0;
      w_b   = '0;
      for (int p = 0; p < 2; p++)
         for (int i = NUM_REQ - 1; i >= 0; i--)
            if (req_valid[i] && ((i > int'(r_ptr)) == (p == 1))) begin
               w_any = 1'b1;
               w_gnt = ID_W'(i);
               w_a   = req_a[8*i +: 8];
               w_b   = req_b[8*i +: 8];
            end
   end
   assign req_ready   = (r_state == S_IDLE && w_any) ? NUM_REQ'(1) << w_gnt : '0;
   assign adder_reset = r_state != S_WAIT;
   assign adder_a     = r_a;
   assign adder_b     = r_b;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_y       = r_y;
   assign rsp_id      = r_rsp_id;
   assign rsp_error   = r_err;
`ifdef FADD_SCHED_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] r_cnt;
   assign w_expire = r_cnt == CW'(TIMEOUT_CYCLES - 1);
   always_ff @(posedge clock)
      if (reset || r_state != S_WAIT) r_cnt <= '0;
      else if (!w_expire) r_cnt <= r_cnt + 1'b1;
`else
   assign w_expire = 1'b0;
`endif
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_ptr       <= ID_W'(NUM_REQ - 1);
         r_id        <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_rsp_valid <= 1'b0;
         r_y         <= '0;
         r_rsp_id    <= '0;
         r_err       <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE:
               if (w_any) begin
                  r_a     <= w_a;
                  r_b     <= w_b;
                  r_id    <= w_gnt;
                  r_ptr   <= w_gnt;
                  r_state <= S_LAUNCH;
               end
            S_LAUNCH: r_state <= S_WAIT;
            S_WAIT:
               if (adder_valid || w_expire) begin
                  r_y         <= adder_valid ? adder_y : 8'h00;
                  r_err       <= !adder_valid;
                  r_rsp_id    <= r_id;
                  r_rsp_valid <= 1'b1;
                  r_state     <= S_RESP;
               end
            default:
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_err       <= 1'b0;
                  r_state     <= S_IDLE;
               end
         endcase
      end
   end
endmodule
